result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader_if.sv | 30 +++
 rtl/result_reader.sv | 150 +++++++++++++++
 tb/tb_result_reader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/result_reader_if.sv
// rtl/result_reader_if.sv - results-SRAM read port and element stream bundle
interface result_reader_if #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8
);
    logic                                   sram_rd_en;
    logic [ADDRESSSIZE-1:0]                 sram_rd_address;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_rd_data;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [PARTIAL_SUM_BW-1:0]              out_data;
    logic [2:0]                             out_row;
    logic [2:0]                             out_col;
    logic                                   out_last;

    modport master (
        output sram_rd_en, sram_rd_address,
        input  sram_rd_data,
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  sram_rd_en, sram_rd_address,
        output sram_rd_data,
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/result_reader.sv
// rtl/result_reader.sv - drains NUM_ROWS results-SRAM rows as a per-element stream
module result_reader #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int NUM_ROWS       = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    result_reader_if.master bus
);
    localparam int         W        = PARTIAL_SUM_BW;
    localparam logic [2:0] ROW_LAST = 3'(NUM_ROWS - 1);
    localparam logic [2:0] COL_LAST = 3'(MATRIX_SIZE - 1);

    typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, SEND, DONE} state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 row_q, row_d;
    logic [2:0]                 col_q, col_d;
    logic [W*MATRIX_SIZE-1:0]   buf_q, buf_d;
    logic                       sram_rd_en_q, sram_rd_en_d;
    logic [ADDRESSSIZE-1:0]     sram_rd_address_q, sram_rd_address_d;
    logic                       out_valid_q, out_valid_d;
    logic [W-1:0]               out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [2:0]                 col_nxt;
    logic [2:0]                 row_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= IDLE;
            row_q             <= '0;
            col_q             <= '0;
            buf_q             <= '0;
            sram_rd_en_q      <= 1'b0;
            sram_rd_address_q <= '0;
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
            out_last_q        <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            row_q             <= row_d;
            col_q             <= col_d;
            buf_q             <= buf_d;
            sram_rd_en_q      <= sram_rd_en_d;
            sram_rd_address_q <= sram_rd_address_d;
            out_valid_q       <= out_valid_d;
            out_data_q        <= out_data_d;
            out_last_q        <= out_last_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        row_d             = row_q;
        col_d             = col_q;
        buf_d             = buf_q;
        sram_rd_en_d      = 1'b0;
        sram_rd_address_d = sram_rd_address_q;
        out_valid_d       = out_valid_q;
        out_data_d        = out_data_q;
        out_last_d        = out_last_q;
        busy_d            = busy_q;
        done_d            = 1'b0;
        col_nxt           = col_q + 3'd1;
        row_nxt           = row_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d           = ADDR;
                    row_d             = '0;
                    col_d             = '0;
                    busy_d            = 1'b1;
                    sram_rd_en_d      = 1'b1;
                    sram_rd_address_d = '0;
                end
            end
            ADDR: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Read data is only valid this cycle, so the first element comes straight off the bus.
                buf_d       = bus.sram_rd_data;
                out_data_d  = bus.sram_rd_data[int'(col_q)*W +: W];
                out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (col_q != COL_LAST) begin
                        col_d      = col_nxt;
                        out_data_d = buf_q[int'(col_nxt)*W +: W];
                        out_last_d = (row_q == ROW_LAST) && (col_nxt == COL_LAST);
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        if (row_q != ROW_LAST) begin
                            row_d             = row_nxt;
                            col_d             = '0;
                            sram_rd_en_d      = 1'b1;
                            sram_rd_address_d = {{(ADDRESSSIZE-3){1'b0}}, row_nxt};
                            state_d           = ADDR;
                        end else begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Cancel wins over any transfer or row fetch decided above.
        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            busy_d       = 1'b0;
            sram_rd_en_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    assign bus.sram_rd_en      = sram_rd_en_q;
    assign bus.sram_rd_address = sram_rd_address_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_row         = row_q;
    assign bus.out_col         = col_q;
    assign bus.out_last        = out_last_q;
    assign busy                = busy_q;
    assign done                = done_q;
endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - randomized self-checking bench for result_reader
module tb_result_reader;
    localparam int AW = 10;
    localparam int W  = 20;
    localparam int M  = 8;
    localparam int R  = 8;

    logic clk = 1'b0;
    logic rstn, start, abort;
    logic busy, done;

    result_reader_if #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(W), .MATRIX_SIZE(M)) bus ();

    result_reader #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(W), .MATRIX_SIZE(M), .NUM_ROWS(R)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W*M-1:0] mem [R];

    always @(posedge clk) begin
        if (bus.sram_rd_en) bus.sram_rd_data <= mem[bus.sram_rd_address[2:0]];
    end

    typedef struct {
        int          row;
        int          col;
        logic [W-1:0] val;
        bit          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        logic [W-1:0] v;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < M; c++) begin
                v = (mode == 2) ? W'($urandom) : W'(r * 8 + c);
                if (mode == 1 && r == 0 && c == 7) v = 20'hFFFFF;
                mem[r][c*W +: W] = v;
            end
        end
    endtask

    task automatic build_model;
        exp_q.delete();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < M; c++)
                exp_q.push_back('{r, c, mem[r][c*W +: W], (r == R-1) && (c == M-1)});
    endtask

    function automatic logic [63:0] all_outputs;
        return {bus.sram_rd_en, bus.sram_rd_address, bus.out_valid, bus.out_data,
                bus.out_row, bus.out_col, bus.out_last, busy, done};
    endfunction

    task automatic run_job(input string name, input bit rand_ready, input int stall_row,
                           input int stall_col, input int abort_row, input int reset_row,
                           input bit restart_mid);
        int    n, beats, stall_left, first_n, last_n, prev_col;
        bit    stalled, ended, prev_xfer, rdy, saw;
        beat_t f;
        build_model();
        beats = 0; stall_left = 0; stalled = 0; first_n = -1; last_n = -1;
        ended = 0; prev_xfer = 0; prev_col = 0;
        start = 1'b1; bus.out_ready = 1'b0;
        tick;
        start = 1'b0; n = 0;
        check({name, "_busy_e0"}, busy, 1);
        while (!ended && n < 300) begin
            rdy = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            if (prev_xfer) check({name, "_valid_after_xfer"}, bus.out_valid, prev_col != M-1);
            prev_xfer = 0;
            if (bus.sram_rd_en && exp_q.size() > 0)
                check({name, "_rd_address"}, bus.sram_rd_address, exp_q[0].row);
            if (done) begin
                check({name, "_beats"}, beats, 64);
                check({name, "_done_after_last"}, n, last_n + 1);
                if (!rand_ready && stall_row < 0) check({name, "_done_cycle"}, n, 80);
                tick;
                check({name, "_done_pulse_end"}, {done, busy}, 2'b00);
                ended = 1;
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_beat"}, bus.out_valid, 0);
                    ended = 1;
                end else begin
                    f = exp_q[0];
                    if (first_n < 0) begin
                        first_n = n;
                        check({name, "_first_valid_cycle"}, n, 2);
                    end
                    check({name, "_data"}, bus.out_data, f.val);
                    check({name, "_row"}, bus.out_row, f.row);
                    check({name, "_col"}, bus.out_col, f.col);
                    check({name, "_last"}, bus.out_last, f.last);
                    if (abort_row == f.row) begin
                        abort = 1'b1; bus.out_ready = 1'b1;
                        tick;
                        abort = 1'b0;
                        check({name, "_abort_outputs"},
                              {bus.out_valid, busy, bus.sram_rd_en, done}, 4'b0000);
                        saw = 0;
                        repeat (10) begin
                            tick;
                            if (done || busy) saw = 1;
                        end
                        check({name, "_no_done_after_abort"}, saw, 0);
                        ended = 1;
                    end else if (reset_row == f.row) begin
                        rstn = 1'b0;
                        #1;
                        check({name, "_reset_outputs"}, all_outputs(), 0);
                        tick; tick;
                        rstn = 1'b1;
                        saw = 0;
                        repeat (8) begin
                            tick;
                            if (busy || bus.out_valid || bus.sram_rd_en) saw = 1;
                        end
                        check({name, "_idle_after_reset"}, saw, 0);
                        ended = 1;
                    end else begin
                        if (stall_left > 0) begin
                            rdy = 1'b0; stall_left--;
                        end else if (!stalled && f.row == stall_row && f.col == stall_col) begin
                            stalled = 1; stall_left = 4; rdy = 1'b0;
                        end
                        if (rdy) begin
                            void'(exp_q.pop_front());
                            beats++;
                            prev_xfer = 1;
                            prev_col = f.col;
                            if (f.last) last_n = n;
                        end
                    end
                end
            end
            if (!ended) begin
                bus.out_ready = rdy;
                start = restart_mid && beats >= 20 && beats < 23;
                tick;
                start = 1'b0;
                n++;
            end
        end
        check({name, "_completed"}, ended, 1);
        if (stall_row >= 0) check({name, "_stall_seen"}, stalled, 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; bus.out_ready = 1'b0;
        for (int r = 0; r < R; r++) mem[r] = '0;
        repeat (3) tick;
        check("reset_outputs", all_outputs(), 0);
        rstn = 1'b1;
        tick;
        check("idle_after_release", {busy, bus.sram_rd_en, bus.out_valid}, 3'b000);

        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {busy, bus.sram_rd_en}, 2'b00);
        tick;
        check("start_abort_no_valid", bus.out_valid, 0);

        fill(0); run_job("basic",       0, -1, -1, -1, -1, 1);
        fill(1); run_job("stall",       1,  3,  4, -1, -1, 0);
        fill(2); run_job("abort",       0, -1, -1,  5, -1, 0);
        fill(2); run_job("after_abort", 1, -1, -1, -1, -1, 0);
        fill(2); run_job("reset",       0, -1, -1, -1,  2, 0);
        fill(2); run_job("after_reset", 0, -1, -1, -1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
